// File: rtl/pkg_opengpu.sv
// Shared types and widths for the OpenGPU blocks; this slice covers the
// data-memory responder's FSM state and latched access record.
package pkg_opengpu;
  localparam int ADDR_WIDTH         = 32;
  localparam int DATA_WIDTH         = 32;
  localparam int DMEM_RSP_LAT_WIDTH = 4;

  typedef enum logic [1:0] {
    RSP_IDLE,
    RSP_WAIT,
    RSP_DONE
  } dmem_rsp_state_t;

  typedef enum logic {
    SRC_CORE,
    SRC_HOST
  } dmem_src_t;

  // One accepted access, captured at arbitration time.
  typedef struct packed {
    dmem_src_t               src;
    logic                    we;
    logic [ADDR_WIDTH-3:0]   idx;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [3:0]              be;
  } dmem_acc_t;
endpackage

// File: rtl/dmem_sram_be.sv
// Single-port word array with per-byte write mask and a registered read port.
module dmem_sram_be
  import pkg_opengpu::*;
#(
  parameter int DEPTH = 1024,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [3:0]            be,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [3:0][7:0] mem [DEPTH];

  // A write cycle leaves rdata untouched; otherwise the addressed word is read.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[addr][b] <= wdata[8*b +: 8];
    end else begin
      rdata <= mem[addr];
    end
  end
endmodule

// File: rtl/dmem_responder.sv
// Target end of the core dmem interface plus a priority host back-door,
// serialising both onto one byte-enabled SRAM with a fixed access latency.
module dmem_responder
  import pkg_opengpu::*;
#(
  parameter int MEM_DEPTH_WORDS = 1024,
  parameter int ACCESS_LATENCY  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  dmem_req,
  input  logic                  dmem_we,
  input  logic [ADDR_WIDTH-1:0] dmem_addr,
  input  logic [DATA_WIDTH-1:0] dmem_wdata,
  input  logic [3:0]            dmem_be,
  output logic [DATA_WIDTH-1:0] dmem_rdata,
  output logic                  dmem_valid,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic                  host_valid,
  output logic                  err
);
  localparam int AW    = $clog2(MEM_DEPTH_WORDS);
  localparam int IDX_W = ADDR_WIDTH - 2;
  localparam logic [DMEM_RSP_LAT_WIDTH-1:0] CNT_LOAD = DMEM_RSP_LAT_WIDTH'(ACCESS_LATENCY - 1);

  dmem_rsp_state_t                state, state_nxt;
  logic [DMEM_RSP_LAT_WIDTH-1:0]  cnt, cnt_nxt;
  dmem_acc_t                      acc, req_acc;
  logic                           any_req;
  logic                           in_range;
  logic                           sram_we;
  logic [AW-1:0]                  sram_addr;
  logic [DATA_WIDTH-1:0]          sram_q;
  logic [DATA_WIDTH-1:0]          rd_word;
  logic                           unused_addr_lsb;

  assign unused_addr_lsb = ^{dmem_addr[1:0], host_addr[1:0]};

  // Host has fixed priority; host writes are always full-word.
  assign any_req = host_req | dmem_req;
  always_comb begin
    req_acc = '0;
    if (host_req) begin
      req_acc.src   = SRC_HOST;
      req_acc.we    = host_we;
      req_acc.idx   = host_addr[ADDR_WIDTH-1:2];
      req_acc.wdata = host_wdata;
      req_acc.be    = 4'hF;
    end else begin
      req_acc.src   = SRC_CORE;
      req_acc.we    = dmem_we;
      req_acc.idx   = dmem_addr[ADDR_WIDTH-1:2];
      req_acc.wdata = dmem_wdata;
      req_acc.be    = dmem_be;
    end
  end

  // The array read is issued on the edge entering RSP_DONE, so in IDLE the
  // address comes straight from the arbiter (covers ACCESS_LATENCY == 1).
  assign sram_addr = (state == RSP_IDLE) ? req_acc.idx[AW-1:0] : acc.idx[AW-1:0];
  assign in_range  = (acc.idx[IDX_W-1:AW] == '0);
  assign sram_we   = (state == RSP_DONE) && acc.we && in_range;
  assign rd_word   = in_range ? sram_q : '0;

  dmem_sram_be #(.DEPTH(MEM_DEPTH_WORDS)) u_sram (
    .clk   (clk),
    .we    (sram_we),
    .addr  (sram_addr),
    .wdata (acc.wdata),
    .be    (acc.be),
    .rdata (sram_q)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      RSP_IDLE: if (any_req) begin
        cnt_nxt   = CNT_LOAD;
        state_nxt = (ACCESS_LATENCY == 1) ? RSP_DONE : RSP_WAIT;
      end
      RSP_WAIT: begin
        cnt_nxt = cnt - 1'b1;
        if (cnt == 1) state_nxt = RSP_DONE;
      end
      RSP_DONE: state_nxt = RSP_IDLE;
      default:  state_nxt = RSP_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RSP_IDLE;
      cnt   <= '0;
      acc   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == RSP_IDLE && any_req) acc <= req_acc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmem_valid <= 1'b0;
      host_valid <= 1'b0;
      err        <= 1'b0;
      dmem_rdata <= '0;
      host_rdata <= '0;
    end else begin
      dmem_valid <= 1'b0;
      host_valid <= 1'b0;
      err        <= 1'b0;
      if (state == RSP_DONE) begin
        dmem_valid <= (acc.src == SRC_CORE);
        host_valid <= (acc.src == SRC_HOST);
        err        <= !in_range;
        if (!acc.we) begin
          if (acc.src == SRC_HOST) host_rdata <= rd_word;
          else                     dmem_rdata <= rd_word;
        end
      end
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed checks for dmem_responder: table of single accesses, then host
// priority, reset-abort and reset-state sequences.
module tb_dmem_responder;
  localparam int DEPTH = 64;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dmem_req, dmem_we, host_req, host_we;
  logic [31:0] dmem_addr, dmem_wdata, host_addr, host_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata, host_rdata;
  logic        dmem_valid, host_valid, err;

  dmem_responder #(.MEM_DEPTH_WORDS(DEPTH), .ACCESS_LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rdata(dmem_rdata),
    .dmem_valid(dmem_valid),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(host_rdata), .host_valid(host_valid),
    .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          host;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  vec_t        vecs[$];
  int          total = 0, passed = 0;
  logic [31:0] last_core = '0, last_host = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Called just after a negedge; returns at the negedge where valid is seen.
  task automatic access(input vec_t v, output logic [31:0] rd, output bit er,
                        output int cyc, output bit other);
    rd = '0; er = 0; cyc = 0; other = 0;
    if (v.host) begin
      host_req = 1; host_we = v.we; host_addr = v.addr; host_wdata = v.wdata;
    end else begin
      dmem_req = 1; dmem_we = v.we; dmem_addr = v.addr; dmem_wdata = v.wdata; dmem_be = v.be;
    end
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (v.host ? host_valid : dmem_valid) begin
        cyc = i; rd = v.host ? host_rdata : dmem_rdata; er = err;
        other = v.host ? dmem_valid : host_valid;
        break;
      end
    end
    host_req = 0; dmem_req = 0;
  endtask

  initial begin
    logic [31:0] rd, hrd, crd;
    bit          er, other;
    int          cyc, hcyc, ccyc, stray;

    //          host we addr           wdata          be       exp_rdata      err
    vecs.push_back('{1, 1, 32'h40,  32'h11223344, 4'h0,    32'h0,         0});
    vecs.push_back('{0, 0, 32'h40,  32'h0,        4'h0,    32'h11223344,  0});
    vecs.push_back('{0, 1, 32'h40,  32'h0000AB00, 4'b0010, 32'h0,         0});
    vecs.push_back('{0, 0, 32'h40,  32'h0,        4'h0,    32'h1122AB44,  0});
    vecs.push_back('{0, 1, 32'h40,  32'hBEEF0000, 4'b1100, 32'h0,         0});
    vecs.push_back('{0, 0, 32'h40,  32'h0,        4'h0,    32'hBEEFAB44,  0});
    vecs.push_back('{1, 1, 32'h0,   32'hCAFEF00D, 4'h0,    32'h0,         0});
    vecs.push_back('{0, 0, 32'h100, 32'h0,        4'h0,    32'h0,         1});
    vecs.push_back('{0, 1, 32'h100, 32'hDEADBEEF, 4'hF,    32'h0,         1});
    vecs.push_back('{1, 0, 32'h0,   32'h0,        4'h0,    32'hCAFEF00D,  0});
    vecs.push_back('{1, 1, 32'hFC,  32'hA5A50001, 4'h0,    32'h0,         0});
    vecs.push_back('{0, 0, 32'hFE,  32'h0,        4'h0,    32'hA5A50001,  0});
    vecs.push_back('{1, 1, 32'h80,  32'h55AA55AA, 4'h0,    32'h0,         0});
    vecs.push_back('{0, 0, 32'h43,  32'h0,        4'h0,    32'hBEEFAB44,  0});
    vecs.push_back('{0, 1, 32'h80,  32'hFFFFFFFF, 4'h0,    32'h0,         0});
    vecs.push_back('{1, 0, 32'h80,  32'h0,        4'h0,    32'h55AA55AA,  0});

    rst_n = 0; dmem_req = 0; dmem_we = 0; dmem_addr = 0; dmem_wdata = 0; dmem_be = 0;
    host_req = 0; host_we = 0; host_addr = 0; host_wdata = 0;
    repeat (2) @(negedge clk);
    check("reset dmem_valid", {31'b0, dmem_valid}, 32'h0);
    check("reset host_valid", {31'b0, host_valid}, 32'h0);
    check("reset err",        {31'b0, err},        32'h0);
    check("reset dmem_rdata", dmem_rdata, 32'h0);
    check("reset host_rdata", host_rdata, 32'h0);
    rst_n = 1;
    @(negedge clk);

    foreach (vecs[n]) begin
      access(vecs[n], rd, er, cyc, other);
      check($sformatf("v%0d latency", n), cyc, LAT + 1);
      check($sformatf("v%0d err", n), {31'b0, er}, {31'b0, vecs[n].exp_err});
      check($sformatf("v%0d other valid", n), {31'b0, other}, 32'h0);
      if (!vecs[n].we) begin
        check($sformatf("v%0d rdata", n), rd, vecs[n].exp_rdata);
        if (vecs[n].host) last_host = vecs[n].exp_rdata;
        else              last_core = vecs[n].exp_rdata;
      end
      @(negedge clk);
      check($sformatf("v%0d dmem_rdata hold", n), dmem_rdata, last_core);
      check($sformatf("v%0d host_rdata hold", n), host_rdata, last_host);
    end

    // Simultaneous requests: host first, core one full access period later.
    hcyc = 0; ccyc = 0; hrd = '0; crd = '0;
    host_req = 1; host_we = 0; host_addr = 32'h40;
    dmem_req = 1; dmem_we = 0; dmem_addr = 32'h0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (host_valid && hcyc == 0) begin hcyc = i; hrd = host_rdata; host_req = 0; end
      if (dmem_valid && ccyc == 0) begin ccyc = i; crd = dmem_rdata; dmem_req = 0; end
      if (hcyc != 0 && ccyc != 0) break;
    end
    host_req = 0; dmem_req = 0;
    check("prio host cycle", hcyc, LAT + 1);
    check("prio core cycle", ccyc, 2 * LAT + 2);
    check("prio host rdata", hrd, 32'hBEEFAB44);
    check("prio core rdata", crd, 32'hCAFEF00D);
    @(negedge clk);

    // Reset during the wait phase of a write abandons it.
    dmem_req = 1; dmem_we = 1; dmem_addr = 32'h80; dmem_wdata = 32'h12345678; dmem_be = 4'hF;
    @(negedge clk);
    dmem_req = 0;
    rst_n = 0;
    #1;
    check("abort dmem_rdata async", dmem_rdata, 32'h0);
    check("abort host_rdata async", host_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1;
    stray = 0;
    repeat (4) begin
      @(negedge clk);
      if (dmem_valid || host_valid || err) stray++;
    end
    check("abort no valid", stray, 0);
    access('{1, 0, 32'h80, 32'h0, 4'h0, 32'h55AA55AA, 0}, rd, er, cyc, other);
    check("abort readback", rd, 32'h55AA55AA);
    check("abort readback latency", cyc, LAT + 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
